divider_32_bit_seq: RTL
=======================

// Module: divider_32_bit_seq
// PURPOSE
//  Multi-cycle restoring divider for the ALU DIV operation. Each step is a trial subtract, the same
//  operation subtractor_32_bit performs. Takes dividend/divisor, produces quotient and remainder.
//  Quotient feeds ZLo and remainder feeds ZHi, so the control unit waits on done before loading Z.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width; step counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk        in   1      rising-edge clock
//  clr        in   1      asynchronous, active-high reset
//  start      in   1      1-cycle request; sampled only in IDLE
//  a          in   WIDTH  dividend, captured on accepted start
//  b          in   WIDTH  divisor, captured on accepted start
//  busy       out  1      high from cycle after accepted start until done cycle (inclusive)
//  done       out  1      1-cycle pulse: q/r valid from this cycle on
//  div_zero   out  1      set with done when captured b==0; held until next accepted start
//  q          out  WIDTH  quotient (-> ZLo)
//  r          out  WIDTH  remainder (-> ZHi)
// BEHAVIOUR
//  - clr asserted (any time, incl. mid-division): state=IDLE, busy=done=div_zero=0, q=r=0, counter=0.
//  - States:
//    IDLE: start=1 -> latch a,b. If b==0 -> DONE; else -> RUN, rem=0, quo=a, count=WIDTH.
//    RUN: one step per cycle. {rem,quo} <<= 1; trial = rem - b (WIDTH+1 bits).
//         If trial >= 0: rem = trial, quo[0]=1; else restore rem, quo[0]=0.
//         count-- ; when count reaches 0 -> FIX (if DIV_SIGNED_EN) else DONE.
//    FIX: sign correction (see CONFIGURATION), one cycle -> DONE.
//    DONE: done=1 for exactly this cycle, q/r registered -> IDLE.
//  - Latency, start accepted at edge N: done high in cycle N+WIDTH+1 unsigned,
//    N+WIDTH+2 signed. For b==0: done at N+1.
//  - Divide by zero: q = all ones, r = a, div_zero=1. No RUN cycles.
//  - start while busy is ignored. It is not queued, and the in-flight operands are unaffected.
//  - start in the DONE cycle is ignored. start in IDLE is accepted, so back-to-back issue is
//    possible one cycle after done.
//  - q, r, div_zero hold their last values until the next accepted start completes.
//    q, r, div_zero are never partially updated while busy.
//  - All arithmetic is unsigned on WIDTH bits. The trial subtract uses WIDTH+1 bits, and its
//    MSB is the borrow.
// CONFIGURATION
//  DIV_SIGNED_EN defined: operands are two's complement.
//   - IDLE captures |a| and |b|, plus sa=a[MSB] and sb=b[MSB]. The magnitude divide runs in RUN.
//   - FIX negates q when sa^sb, and negates r when sa. Result truncates toward zero.
//   - -2^(W-1) / -1 gives q=0x80000000, r=0 (wrap; no flag).
//   - Div by zero: q=all ones, r=a (original signed a), FIX skipped.
//  DIV_SIGNED_EN undefined: FIX state absent; operands are unsigned; latency WIDTH+1.
// TESTING
//  1. a=32'h4, b=32'h2, start 1 cycle -> done at +33 (unsigned), q=2, r=0, div_zero=0.
//  2. a=32'd100, b=32'd7 -> q=14, r=2. Then a=32'hFFFFFFFF, b=1 -> q=32'hFFFFFFFF, r=0.
//  3. a=32'h44444444, b=0 -> done 1 cycle after start, div_zero=1, q=32'hFFFFFFFF, r=32'h44444444.
//  4. start pulsed again at cycles +5 and +20 of a running divide -> ignored; result of the
//     first divide is unchanged.
//     Then clr pulsed at cycle +10 of a new divide -> busy=0, q=r=0 immediately; the next
//     start runs normally.
//  5. (DIV_SIGNED_EN) a=-7, b=2 -> q=-3, r=-1 at +34. a=7, b=-2 -> q=-3, r=1.
//     a=32'h80000000, b=-1 -> q=32'h80000000, r=0.
//  6. Random unsigned a/b (b!=0) for 1000 ops, issued back-to-back:
//     - check q*b+r==a and r<b against a reference model;
//     - check done is a single-cycle pulse per accepted start.

Source files
------------

// File: rtl/divider_32_bit_seq.sv
// Multi-cycle restoring divider: one trial subtract per cycle, quotient -> ZLo, remainder -> ZHi.
// Define DIV_SIGNED_EN for two's-complement operands (adds a one-cycle FIX sign-correction state).
module divider_32_bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH) + 1;

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef DIV_SIGNED_EN
    logic sa_q, sa_d;
    logic sb_q, sb_d;
    assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // The shifted remainder is always < 2*divisor, so a WIDTH+1 bit difference never wraps
    // past zero and its MSB alone is the borrow.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign borrow   = trial[WIDTH];
    assign rem_step = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvs_d = b_mag;
`ifdef DIV_SIGNED_EN
                    sa_d  = a[WIDTH-1];
                    sb_d  = b[WIDTH-1];
`endif
                    if (b == '0) begin
                        q_d     = '1;
                        r_d     = a;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef DIV_SIGNED_EN
                    state_d = S_FIX;
`else
                    // Results are published only at completion so q/r never show partial values.
                    q_d     = quo_step;
                    r_d     = rem_step;
                    dz_d    = 1'b0;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            S_FIX: begin
                q_d     = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
                r_d     = sa_q ? (~rem_q + 1'b1) : rem_q;
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
    assign q        = q_q;
    assign r        = r_q;

endmodule
